framebuffer_write_arbiter: RTL

Shares the single framebuffer write port (en_write_framebuffer / framebuffer_addr / framebuffer_data) between N_REQ drawing clients, such as the test card, the raycast column renderer and debug overlays. It uses round-robin arbitration with a valid/ready handshake, one write per cycle. It also contains a clear-screen sequencer that, when triggered, owns the port and fills every pixel with CLEAR_COLOR. It sits directly in front of the framebuffer BRAM write port.

---
 rtl/framebuffer_write_arbiter_if.sv | 33 +++
 rtl/framebuffer_write_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/framebuffer_write_arbiter_if.sv
// Requester handshake bundle plus the framebuffer BRAM write port.
// The arbiter uses the slave modport; clients and the framebuffer side use master.
interface framebuffer_write_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*20-1:0] req_addr;
    logic [N_REQ*6-1:0]  req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                en_write_framebuffer;
    logic [19:0]         framebuffer_addr;
    logic [5:0]          framebuffer_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  en_write_framebuffer,
        input  framebuffer_addr,
        input  framebuffer_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output en_write_framebuffer,
        output framebuffer_addr,
        output framebuffer_data
    );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port, with a full-screen
// clear sequencer that takes over the port while it runs.
//
// state | meaning
// ARB   | round-robin grant to requesters, one write per cycle
// CLEAR | sequencer writes CLEAR_COLOR to every pixel, requesters stalled
module framebuffer_write_arbiter #(
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          N_REQ       = 3,
    parameter logic [5:0]  CLEAR_COLOR = 6'd0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    framebuffer_write_arbiter_if.slave  bus,
    input  logic                        clear_start,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic [7:0]                  drop_count
);
    localparam int          IDX_W     = $clog2(N_REQ);
    localparam logic [19:0] PIX_TOTAL = 20'(H_RES * V_RES);
    localparam logic [19:0] PIX_LAST  = PIX_TOTAL - 20'd1;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_last;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic [19:0]      grant_addr;
    logic [5:0]       grant_data;
    logic [19:0]      clear_cnt;

    // Two descending passes: the second pass overrides with the lowest index
    // above rr_last, so wrap-around candidates only win when none are above it.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = rr_last;
        grant_addr = '0;
        grant_data = '0;
        if (state == ARB && !clear_start) begin
            for (int j = N_REQ - 1; j >= 0; j--) begin
                if (bus.req_valid[j] && (IDX_W'(j) <= rr_last)) begin
                    grant_vld  = 1'b1;
                    grant_idx  = IDX_W'(j);
                    grant_addr = bus.req_addr[20*j +: 20];
                    grant_data = bus.req_data[6*j +: 6];
                end
            end
            for (int j = N_REQ - 1; j >= 0; j--) begin
                if (bus.req_valid[j] && (IDX_W'(j) > rr_last)) begin
                    grant_vld  = 1'b1;
                    grant_idx  = IDX_W'(j);
                    grant_addr = bus.req_addr[20*j +: 20];
                    grant_data = bus.req_data[6*j +: 6];
                end
            end
        end
    end

    assign bus.req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (clear_cnt == PIX_LAST) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last                  <= IDX_W'(N_REQ - 1);
            clear_cnt                <= '0;
            clear_busy               <= 1'b0;
            clear_done               <= 1'b0;
            drop_count               <= '0;
            bus.en_write_framebuffer <= 1'b0;
            bus.framebuffer_addr     <= '0;
            bus.framebuffer_data     <= '0;
        end else begin
            bus.en_write_framebuffer <= 1'b0;
            clear_busy               <= 1'b0;
            clear_done               <= 1'b0;
            case (state)
                ARB: begin
                    if (grant_vld) begin
                        rr_last <= grant_idx;
                        if (grant_addr < PIX_TOTAL) begin
                            bus.en_write_framebuffer <= 1'b1;
                            bus.framebuffer_addr     <= grant_addr;
                            bus.framebuffer_data     <= grant_data;
                        end else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                    if (clear_start) begin
                        clear_cnt <= '0;
                    end
                end
                CLEAR: begin
                    bus.en_write_framebuffer <= 1'b1;
                    bus.framebuffer_addr     <= clear_cnt;
                    bus.framebuffer_data     <= CLEAR_COLOR;
                    clear_busy               <= 1'b1;
                    clear_done               <= (clear_cnt == PIX_LAST);
                    clear_cnt                <= (clear_cnt == PIX_LAST) ? 20'd0 : clear_cnt + 20'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
